aes_round_key_store: RTL and testbench
======================================

// Module: aes_round_key_store
// PURPOSE
// - AES-128 key-schedule front end. Accepts one 128-bit cipher key over a valid/ready handshake.
// - Iterates the key expansion one round per clock and stores all 11 round keys (rk[0..10]) in a register file.
// - Serves the stored keys to the cipher datapath through a registered random-access read port.
// - Sits between the key source and the round pipeline; replaces the testbench-style feedback loop of key -> round_key.
// PARAMETERS
// - NR     10   number of rounds; AES-128 only, so 10 is the only legal value
// - KEY_W  128  key and round-key width in bits; bit 0 is the MSB, as in the [0:127] convention
// PORTS
// - clk        in   1      single clock; all state updates on the rising edge
// - rst_n      in   1      reset: synchronous, active-low
// - key_in     in   0:127  cipher key, sampled on an accept
// - key_valid  in   1      key_in is valid
// - key_ready  out  1      block can accept a key; high in IDLE and DONE
// - busy       out  1      expansion in progress; high in EXPAND
// - keys_done  out  1      rk[0..10] are all valid for the key last accepted
// - rd_round   in   4      round-key index to read, 0..10
// - rd_key     out  0:127  registered read data
// BEHAVIOUR
// - Reset (rst_n==0 at an edge) sets:
//   - state = IDLE, cnt = 0
//   - keys_done = 0, busy = 0, rd_key = 0
//   - all rk entries = 0
//   - key_ready = 1 in the cycle after reset
// - FSM has three states: IDLE, EXPAND, DONE.
// - Accept condition: key_valid && key_ready at an edge (edge E0).
//   - At E0: rk[0] <= key_in, cnt <= 1, keys_done <= 0, state -> EXPAND.
// - EXPAND, each edge Ek (k = 1..10):
//   - rk[k] <= step(rk[k-1], RCON[k]); cnt <= cnt + 1.
//   - At E10: state -> DONE, keys_done <= 1.
//   - Total latency is 10 cycles from accept to keys_done.
// - step(w, rc):
//   - t = SubWord(RotWord(w[96:127])) ^ {rc, 24'h0}
//   - n0 = w[0:31] ^ t; n1 = w[32:63] ^ n0; n2 = w[64:95] ^ n1; n3 = w[96:127] ^ n2
//   - result = {n0, n1, n2, n3}
// - RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
// - key_ready = 0 in EXPAND. key_valid in EXPAND is ignored and is not queued.
// - In DONE, a new accept restarts at E0 behaviour:
//   - keys_done drops on the accept edge.
//   - Old rk[1..10] stay readable until overwritten.
// - Read port:
//   - rd_key <= (rd_round <= 10) ? rk[rd_round] : 0 on every edge; latency 1 cycle.
//   - Reads during EXPAND are legal. Entries with index >= cnt return their previous contents.
// - Simultaneous events:
//   - A read of index k on edge Ek returns the old rk[k]; no write-through.
// - Reset mid-EXPAND aborts: all state and outputs return to reset values; no partial keys_done.
// STRUCTURE
// - aes_pkg: RCON table, sbox function (FIPS-197 S-box), SubWord/RotWord functions, FSM state localparams, NR/KEY_W constants.
// - Sub-module key_expand_step: combinational step(w, rc), 128-bit in/out plus an 8-bit rc input.
//   - Instantiated once and fed from rk[cnt-1] via a mux.
// - Top level holds the FSM, cnt, the 11 x 128 register file and the read register.
// TESTING
// - Zero key:
//   - rk[1] = 62636363626363636263636362636363
//   - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e
//   - keys_done rises exactly 10 cycles after the accept
// - FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
//   - rk[1] = a0fafe1788542cb123a339392a6c7605
//   - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6
// - key_valid held high with a different key during EXPAND:
//   - key_ready = 0 throughout, busy = 1
//   - stored keys match the first key only
// - Reset pulse at cycle 5 of EXPAND:
//   - next cycle keys_done = 0, rd_key = 0, key_ready = 1
//   - all rk read back as 0
// - Read port:
//   - rd_round = 11 or 15 -> rd_key = 0 one cycle later
//   - rd_round = 0 after zero-key accept -> rd_key = 0
// - Restart from DONE:
//   - zero key, then the FIPS key back-to-back
//   - keys_done low for exactly 10 cycles, then rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6

Source files
------------

// File: rtl/aes_round_key_store_pkg.sv
// AES-128 key-schedule shared definitions: sizes, types, FSM states, S-box,
// RotWord/SubWord helpers and the round-constant lookup.
// Pure package: no latency, no flow control of its own.
package aes_round_key_store_pkg;

    localparam int NR    = 10;   // AES-128 only
    localparam int KEY_W = 128;  // bit 0 is the MSB

    typedef logic [0:KEY_W-1] key_t;
    typedef logic [0:31]      word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // FIPS-197 S-box, byte 0x00 in bits [0:7], byte 0xff in bits [2040:2047].
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {b, 3'b000};
        return SBOX_TBL[base +: 8];
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[8:31], w[0:7]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
    endfunction

    // Round constant for the step that produces rk[k], k = 1..NR.
    function automatic logic [7:0] rcon(input logic [3:0] k);
        logic [7:0] rc;
        case (k)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_round_key_store_if.sv
// Key-store bus: key load handshake, status flags and the round-key read port.
// No latency of its own; key_valid/key_ready handshake, key_valid never queued.
// Ports: master = key source / cipher datapath, slave = aes_round_key_store.
interface aes_round_key_store_if;
    import aes_round_key_store_pkg::*;

    key_t       key_in;
    logic       key_valid;
    logic       key_ready;
    logic       busy;
    logic       keys_done;
    logic [3:0] rd_round;
    key_t       rd_key;

    modport master (
        output key_in, key_valid, rd_round,
        input  key_ready, busy, keys_done, rd_key
    );

    modport slave (
        input  key_in, key_valid, rd_round,
        output key_ready, busy, keys_done, rd_key
    );
endinterface

// File: rtl/aes_round_key_store_key_expand_step.sv
// One AES-128 key-expansion step: next round key from previous key and rcon.
// Purely combinational, zero latency; no flow control.
// Ports: w_i previous round key, rc_i round constant, w_o next round key.
module aes_round_key_store_key_expand_step
    import aes_round_key_store_pkg::*;
(
    input  key_t       w_i,
    input  logic [7:0] rc_i,
    output key_t       w_o
);
    word_t t, n0, n1, n2, n3;

    assign t  = sub_word(rot_word(w_i[96:127])) ^ {rc_i, 24'h000000};
    assign n0 = w_i[0:31]   ^ t;
    assign n1 = w_i[32:63]  ^ n0;
    assign n2 = w_i[64:95]  ^ n1;
    assign n3 = w_i[96:127] ^ n2;
    assign w_o = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_round_key_store.sv
// AES-128 round-key store: loads a cipher key, expands rk[1..10] one per clock.
// Latency: keys_done 10 cycles after accept; rd_key 1 cycle after rd_round.
// Backpressure: key_ready low while expanding; key_valid then ignored, not queued.
// Ports: clk, rst_n (sync, active-low), kif slave side of the key-store bus.
module aes_round_key_store
    import aes_round_key_store_pkg::*;
(
    input logic                  clk,
    input logic                  rst_n,
    aes_round_key_store_if.slave kif
);
    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    key_t       rk_q [0:NR];
    key_t       rd_key_q;
    logic       keys_done_q;

    logic       key_ready_c;
    logic       busy_c;
    logic       accept;
    key_t       step_in;
    key_t       step_out;
    key_t       rd_data;
    logic [7:0] rc;

    always_comb begin
        state_d     = state_q;
        key_ready_c = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                key_ready_c = 1'b1;
                if (kif.key_valid) state_d = ST_EXPAND;
            end
            ST_EXPAND: begin
                busy_c = 1'b1;
                if (cnt_q == 4'(NR)) state_d = ST_DONE;
            end
            ST_DONE: begin
                key_ready_c = 1'b1;
                if (kif.key_valid) state_d = ST_EXPAND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = kif.key_valid && key_ready_c;

    // cnt_q names the entry being written, so the step input is rk[cnt_q-1].
    always_comb begin
        step_in = '0;
        for (int i = 1; i <= NR; i++) begin
            if (cnt_q == 4'(i)) step_in = rk_q[i-1];
        end
    end

    // Indices 11..15 read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i <= NR; i++) begin
            if (kif.rd_round == 4'(i)) rd_data = rk_q[i];
        end
    end

    assign rc = rcon(cnt_q);

    aes_round_key_store_key_expand_step u_step (
        .w_i  (step_in),
        .rc_i (rc),
        .w_o  (step_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            keys_done_q <= 1'b0;
            rd_key_q    <= '0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            // Read samples pre-edge contents: a same-edge write is not forwarded.
            rd_key_q <= rd_data;
            if (accept) begin
                rk_q[0]     <= kif.key_in;
                cnt_q       <= 4'd1;
                keys_done_q <= 1'b0;
            end else if (state_q == ST_EXPAND) begin
                for (int i = 1; i <= NR; i++) begin
                    if (cnt_q == 4'(i)) rk_q[i] <= step_out;
                end
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'(NR)) keys_done_q <= 1'b1;
            end
        end
    end

    assign kif.key_ready = key_ready_c;
    assign kif.busy      = busy_c;
    assign kif.keys_done = keys_done_q;
    assign kif.rd_key    = rd_key_q;
endmodule

// File: tb/tb_aes_round_key_store.sv
// Bench for aes_round_key_store: known-answer round keys, timing, restart,
// ignored keys during expansion, out-of-range reads and mid-expansion reset.
module tb_aes_round_key_store;
    import aes_round_key_store_pkg::*;

    localparam key_t ZERO_KEY  = 128'h0;
    localparam key_t ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam key_t ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam key_t FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam key_t FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam key_t FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam key_t JUNK_KEY  = 128'hdeadbeef0123456789abcdeffedcba98;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_round_key_store_if kif();

    aes_round_key_store dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    key_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Drive a read index at a falling edge and queue the expected data;
    // returns one falling edge later, when rd_key holds the result.
    task automatic issue_read(input logic [3:0] idx, input key_t exp);
        kif.rd_round = idx;
        exp_q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic accept_key(input key_t k);
        kif.key_in    = k;
        kif.key_valid = 1'b1;
        @(negedge clk);
        kif.key_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycles from the accept edge until keys_done is seen, capped at 20.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!kif.keys_done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        key_t got, exp;
        rst_n         = 1'b0;
        kif.key_in    = '0;
        kif.key_valid = 1'b0;
        kif.rd_round  = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (kif.key_ready !== 1'b1) begin n_err++; $display("FAIL reset key_ready: got %b want 1", kif.key_ready); end
        n_cmp++; if (kif.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", kif.busy); end
        n_cmp++; if (kif.keys_done !== 1'b0) begin n_err++; $display("FAIL reset keys_done: got %b want 0", kif.keys_done); end
        n_cmp++; if (kif.rd_key !== '0) begin n_err++; $display("FAIL reset rd_key: got %h want 0", kif.rd_key); end
        for (int i = 0; i <= 10; i += 5) begin
            issue_read(4'(i), '0);
            got = kif.rd_key; exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset rk[%0d]: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_zero_key();
        int         cyc;
        logic [3:0] idx [3];
        key_t       ex  [3];
        key_t       got, exp;
        accept_key(ZERO_KEY);
        n_cmp++; if (kif.busy !== 1'b1) begin n_err++; $display("FAIL zero_key busy: got %b want 1", kif.busy); end
        wait_done(cyc);
        n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL zero_key latency: got %0d want 10 cycles", cyc); end
        idx[0] = 4'd0;  ex[0] = ZERO_KEY;
        idx[1] = 4'd1;  ex[1] = ZERO_RK1;
        idx[2] = 4'd10; ex[2] = ZERO_RK10;
        for (int i = 0; i < 3; i++) begin
            issue_read(idx[i], ex[i]);
            got = kif.rd_key; exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL zero_key rk[%0d]: got %h want %h", idx[i], got, exp); end
        end
    endtask

    task automatic test_restart();
        int   cyc, low;
        key_t got, exp;
        accept_key(ZERO_KEY);
        wait_done(cyc);
        n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL restart first latency: got %0d want 10", cyc); end
        // Back-to-back accept; keep reading rk[10], which must stay old until
        // after the edge that overwrites it.
        kif.key_in    = FIPS_KEY;
        kif.key_valid = 1'b1;
        kif.rd_round  = 4'd10;
        exp_q.push_back(ZERO_RK10);
        @(negedge clk);
        kif.key_valid = 1'b0;
        n_cmp++; if (kif.keys_done !== 1'b0) begin n_err++; $display("FAIL restart keys_done drop: got %b want 0", kif.keys_done); end
        got = kif.rd_key; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL restart old rk10 at E0: got %h want %h", got, exp); end
        low = 0;
        while (!kif.keys_done && low < 20) begin
            exp_q.push_back(ZERO_RK10);
            @(negedge clk);
            low++;
            got = kif.rd_key; exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL restart old rk10 at E%0d: got %h want %h", low, got, exp); end
        end
        n_cmp++; if (low !== 10) begin n_err++; $display("FAIL restart keys_done low cycles: got %0d want 10", low); end
        issue_read(4'd10, FIPS_RK10);
        got = kif.rd_key; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL restart rk[10]: got %h want %h", got, exp); end
        issue_read(4'd1, FIPS_RK1);
        got = kif.rd_key; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL restart rk[1]: got %h want %h", got, exp); end
    endtask

    task automatic test_key_during_expand();
        key_t got, exp;
        pulse_reset();
        kif.key_in    = FIPS_KEY;
        kif.key_valid = 1'b1;
        @(negedge clk);
        kif.key_in = JUNK_KEY;
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (kif.key_ready !== 1'b0) begin n_err++; $display("FAIL hold key_ready after E%0d: got %b want 0", c, kif.key_ready); end
            n_cmp++; if (kif.busy !== 1'b1) begin n_err++; $display("FAIL hold busy after E%0d: got %b want 1", c, kif.busy); end
            if (c == 9) kif.key_valid = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (kif.keys_done !== 1'b1) begin n_err++; $display("FAIL hold keys_done: got %b want 1", kif.keys_done); end
        issue_read(4'd0, FIPS_KEY);
        got = kif.rd_key; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL hold rk[0]: got %h want %h", got, exp); end
        issue_read(4'd1, FIPS_RK1);
        got = kif.rd_key; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL hold rk[1]: got %h want %h", got, exp); end
        issue_read(4'd10, FIPS_RK10);
        got = kif.rd_key; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL hold rk[10]: got %h want %h", got, exp); end
    endtask

    task automatic test_read_oob();
        logic [3:0] idx [4];
        key_t       ex  [4];
        key_t       got, exp;
        idx[0] = 4'd11; ex[0] = '0;
        idx[1] = 4'd10; ex[1] = FIPS_RK10;
        idx[2] = 4'd15; ex[2] = '0;
        idx[3] = 4'd0;  ex[3] = FIPS_KEY;
        for (int i = 0; i < 4; i++) begin
            issue_read(idx[i], ex[i]);
            got = kif.rd_key; exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL read rd_round=%0d: got %h want %h", idx[i], got, exp); end
        end
    endtask

    task automatic test_reset_mid_expand();
        key_t got, exp;
        kif.rd_round = 4'd10;
        accept_key(ZERO_KEY);
        repeat (5) @(negedge clk);
        pulse_reset();
        n_cmp++; if (kif.keys_done !== 1'b0) begin n_err++; $display("FAIL midrst keys_done: got %b want 0", kif.keys_done); end
        n_cmp++; if (kif.rd_key !== '0) begin n_err++; $display("FAIL midrst rd_key: got %h want 0", kif.rd_key); end
        n_cmp++; if (kif.key_ready !== 1'b1) begin n_err++; $display("FAIL midrst key_ready: got %b want 1", kif.key_ready); end
        n_cmp++; if (kif.busy !== 1'b0) begin n_err++; $display("FAIL midrst busy: got %b want 0", kif.busy); end
        for (int i = 0; i <= 10; i++) begin
            issue_read(4'(i), '0);
            got = kif.rd_key; exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL midrst rk[%0d]: got %h want %h", i, got, exp); end
        end
        n_cmp++; if (kif.keys_done !== 1'b0) begin n_err++; $display("FAIL midrst late keys_done: got %b want 0", kif.keys_done); end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_restart();
        test_key_during_expand();
        test_read_oob();
        test_reset_mid_expand();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard leftover: got %0d want 0 entries", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
